// File: rtl/fetch_sequencer.sv
// Fetch controller: issues one instruction-memory fetch at a time, hands words to decode,
// and turns execute redirects into program-counter stall/branch/jump controls.
module fetch_sequencer #(
    parameter int unsigned INSTR_ADDR_WIDTH = 32,
    parameter int unsigned INSTR_WIDTH      = 32,
    parameter int unsigned CNT_WIDTH        = 16
) (
    input  logic                        clk,
    input  logic                        async_rst_n,
    input  logic                        clk_en,
    input  logic [INSTR_ADDR_WIDTH-1:0] pc_addr,
    output logic                        pc_stall,
    output logic                        pc_branch_en,
    output logic                        pc_jump_en,
    output logic                        imem_req_valid,
    input  logic                        imem_req_ready,
    output logic [INSTR_ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                        imem_rsp_valid,
    input  logic [INSTR_WIDTH-1:0]      imem_rsp_data,
    output logic                        instr_valid,
    input  logic                        instr_ready,
    output logic [INSTR_WIDTH-1:0]      instr_data,
    output logic [INSTR_ADDR_WIDTH-1:0] instr_addr,
    input  logic                        redirect_valid,
    input  logic                        redirect_is_branch,
    input  logic [4:0]                  redirect_cond,
    input  logic [4:0]                  flags,
    output logic [CNT_WIDTH-1:0]        taken_count
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_FLUSH
    } state_t;

    state_t                        state_q;
    state_t                        state_d;
    logic                          req_valid_d;
    logic [INSTR_ADDR_WIDTH-1:0]   req_addr_d;
    logic                          instr_valid_d;
    logic [INSTR_WIDTH-1:0]        instr_data_d;
    logic [INSTR_ADDR_WIDTH-1:0]   instr_addr_d;
    logic [CNT_WIDTH-1:0]          taken_count_d;

    logic                          cond_met_c;
    logic                          taken_c;
    logic                          advance_c;
    logic                          req_fire_c;

    // Redirect resolution and program-counter controls
    always_comb begin
        cond_met_c   = (redirect_cond == 5'b00000) || (|(redirect_cond & flags));
        taken_c      = clk_en && redirect_valid && cond_met_c;
        advance_c    = clk_en && instr_valid && instr_ready && !taken_c;
        req_fire_c   = imem_req_valid && imem_req_ready;
        pc_branch_en = taken_c && redirect_is_branch;
        pc_jump_en   = taken_c && !redirect_is_branch;
        pc_stall     = !(taken_c || advance_c);
    end

    // Next state and next values of all registered outputs
    always_comb begin
        state_d       = state_q;
        req_valid_d   = imem_req_valid;
        req_addr_d    = imem_req_addr;
        instr_valid_d = instr_valid;
        instr_data_d  = instr_data;
        instr_addr_d  = instr_addr;
        taken_count_d = taken_count;

        if (taken_c && (taken_count != CNT_MAX)) begin
            taken_count_d = taken_count + CNT_WIDTH'(1);
        end

        unique case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end
            // First REQ cycle samples pc_addr after any counter update has settled
            S_REQ: begin
                if (taken_c) begin
                    req_valid_d = 1'b0;
                    if (req_fire_c) begin
                        state_d = S_FLUSH;
                    end
                end else if (req_fire_c) begin
                    req_valid_d = 1'b0;
                    state_d     = S_WAIT;
                end else if (!imem_req_valid) begin
                    req_valid_d = 1'b1;
                    req_addr_d  = pc_addr;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    if (taken_c) begin
                        state_d = S_REQ;
                    end else begin
                        state_d       = S_HOLD;
                        instr_valid_d = 1'b1;
                        instr_data_d  = imem_rsp_data;
                        instr_addr_d  = imem_req_addr;
                    end
                end else if (taken_c) begin
                    state_d = S_FLUSH;
                end
            end
            S_HOLD: begin
                if (taken_c || instr_ready) begin
                    instr_valid_d = 1'b0;
                    state_d       = S_REQ;
                end
            end
            S_FLUSH: begin
                if (imem_rsp_valid) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; clk_en low freezes everything
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state_q        <= S_IDLE;
            imem_req_valid <= 1'b0;
            imem_req_addr  <= '0;
            instr_valid    <= 1'b0;
            instr_data     <= '0;
            instr_addr     <= '0;
            taken_count    <= '0;
        end else if (clk_en) begin
            state_q        <= state_d;
            imem_req_valid <= req_valid_d;
            imem_req_addr  <= req_addr_d;
            instr_valid    <= instr_valid_d;
            instr_data     <= instr_data_d;
            instr_addr     <= instr_addr_d;
            taken_count    <= taken_count_d;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: PC and memory models around the DUT, directed stimulus,
// and a scoreboard of expected (addr, data) pairs popped on each decode acceptance.
module tb_fetch_sequencer;

    logic        clk;
    logic        async_rst_n;
    logic        clk_en;
    logic [31:0] pc_addr;
    logic        pc_stall;
    logic        pc_branch_en;
    logic        pc_jump_en;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_addr;
    logic        redirect_valid;
    logic        redirect_is_branch;
    logic [4:0]  redirect_cond;
    logic [4:0]  flags;
    logic [15:0] taken_count;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          acc_cnt  = 0;
    int          stall_low_cnt = 0;
    int          br_cnt   = 0;
    int          jp_cnt   = 0;
    int          both_cnt = 0;
    int          dead_cnt = 0;
    int          mem_lat  = 0;
    bit          mem_override = 1'b0;
    int          mem_cnt;
    logic [31:0] mem_data;
    logic [63:0] exp_q[$];

    fetch_sequencer dut (
        .clk                (clk),
        .async_rst_n        (async_rst_n),
        .clk_en             (clk_en),
        .pc_addr            (pc_addr),
        .pc_stall           (pc_stall),
        .pc_branch_en       (pc_branch_en),
        .pc_jump_en         (pc_jump_en),
        .imem_req_valid     (imem_req_valid),
        .imem_req_ready     (imem_req_ready),
        .imem_req_addr      (imem_req_addr),
        .imem_rsp_valid     (imem_rsp_valid),
        .imem_rsp_data      (imem_rsp_data),
        .instr_valid        (instr_valid),
        .instr_ready        (instr_ready),
        .instr_data         (instr_data),
        .instr_addr         (instr_addr),
        .redirect_valid     (redirect_valid),
        .redirect_is_branch (redirect_is_branch),
        .redirect_cond      (redirect_cond),
        .flags              (flags),
        .taken_count        (taken_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Program counter model: branch -> 0x100, jump -> pc+0x40, advance -> pc+2
    always @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) pc_addr <= 32'h0;
        else if (pc_branch_en) pc_addr <= 32'h100;
        else if (pc_jump_en) pc_addr <= pc_addr + 32'h40;
        else if (!pc_stall) pc_addr <= pc_addr + 32'h2;
    end

    // Memory model: response mem_lat cycles after handshake; mem_lat 0 never answers
    always @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            mem_cnt        <= 0;
            mem_data       <= 32'h0;
            imem_rsp_valid <= 1'b0;
            imem_rsp_data  <= 32'h0;
        end else begin
            imem_rsp_valid <= 1'b0;
            if (imem_req_valid && imem_req_ready) begin
                if (mem_lat == 1) begin
                    imem_rsp_valid <= 1'b1;
                    imem_rsp_data  <= mem_override ? 32'hDEADBEEF : {16'hC0DE, imem_req_addr[15:0]};
                end else if (mem_lat > 1) begin
                    mem_cnt  <= mem_lat - 1;
                    mem_data <= mem_override ? 32'hDEADBEEF : {16'hC0DE, imem_req_addr[15:0]};
                end
            end else if (mem_cnt != 0) begin
                mem_cnt <= mem_cnt - 1;
                if (mem_cnt == 1) begin
                    imem_rsp_valid <= 1'b1;
                    imem_rsp_data  <= mem_data;
                end
            end
        end
    end

    // Monitor and scoreboard, sampled mid-cycle
    always begin
        @(negedge clk);
        #2;
        if (async_rst_n) begin
            if (!pc_stall) stall_low_cnt++;
            if (pc_branch_en) br_cnt++;
            if (pc_jump_en) jp_cnt++;
            if (pc_branch_en && pc_jump_en) both_cnt++;
            if (instr_valid && instr_data == 32'hDEADBEEF) dead_cnt++;
            if (clk_en && instr_valid && instr_ready) begin
                acc_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_instr", {instr_addr, instr_data}, 64'h0);
                end else begin
                    check("sb_instr", {instr_addr, instr_data}, exp_q.pop_front());
                end
            end
        end
    end

    task automatic wait_req(input int budget, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            #3;
            cycles++;
        end while (!imem_req_valid && cycles < budget);
    endtask

    task automatic wait_acc(input int target, input int budget);
        int c = 0;
        do begin
            @(negedge clk);
            #3;
            c++;
        end while (acc_cnt < target && c < budget);
        check("acc_timeout", 64'(acc_cnt >= target), 64'h1);
    endtask

    task automatic wait_ivalid(input int budget);
        int c = 0;
        do begin
            @(negedge clk);
            #3;
            c++;
        end while (!instr_valid && c < budget);
        check("ivalid_timeout", 64'(instr_valid), 64'h1);
    endtask

    initial begin
        int cyc;
        int a0;
        int s0;
        int b0;
        int j0;

        async_rst_n        = 1'b0;
        clk_en             = 1'b1;
        imem_req_ready     = 1'b1;
        instr_ready        = 1'b0;
        redirect_valid     = 1'b0;
        redirect_is_branch = 1'b0;
        redirect_cond      = 5'b0;
        flags              = 5'b0;

        // Reset values
        repeat (3) @(negedge clk);
        #3;
        check("reset_ctl", {59'h0, imem_req_valid, instr_valid, pc_stall, pc_branch_en, pc_jump_en}, 64'h4);
        check("reset_cnt", 64'(taken_count), 64'h0);

        // 1: first request, then reset while WAIT
        @(negedge clk);
        async_rst_n = 1'b1;
        wait_req(10, cyc);
        check("first_req_valid", 64'(imem_req_valid), 64'h1);
        check("first_req_addr", 64'(imem_req_addr), 64'h0);
        @(negedge clk);
        @(negedge clk);
        #2;
        async_rst_n = 1'b0;
        #1;
        check("midwait_reset_ctl", {59'h0, imem_req_valid, instr_valid, pc_stall, pc_branch_en, pc_jump_en}, 64'h4);
        check("midwait_reset_data", {instr_addr, instr_data}, 64'h0);
        check("midwait_reset_cnt", {imem_req_addr, 16'h0, taken_count}, 64'h0);

        // 2: release into straight-line fetch
        @(negedge clk);
        async_rst_n = 1'b1;
        mem_lat     = 1;
        instr_ready = 1'b1;
        a0 = acc_cnt;
        s0 = stall_low_cnt;
        exp_q.push_back({32'h0, 32'hC0DE0000});
        exp_q.push_back({32'h2, 32'hC0DE0002});
        exp_q.push_back({32'h4, 32'hC0DE0004});
        wait_req(10, cyc);
        check("idle_then_req_cycles", 64'(cyc), 64'h2);
        check("rerelease_req_addr", 64'(imem_req_addr), 64'h0);
        wait_acc(a0 + 3, 60);
        check("stall_low_per_accept", 64'(stall_low_cnt - s0), 64'h3);

        // 3: decode backpressure on the word at 0x6
        @(negedge clk);
        instr_ready = 1'b0;
        wait_ivalid(20);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #3;
            check("bp_data", 64'(instr_data), 64'hC0DE0006);
            check("bp_ctl", {29'h0, instr_valid, pc_stall, imem_req_valid, instr_addr}, {29'h0, 3'b110, 32'h6});
        end

        // 4: conditional redirect, not taken then taken
        b0 = br_cnt;
        @(negedge clk);
        redirect_valid     = 1'b1;
        redirect_is_branch = 1'b1;
        redirect_cond      = 5'b00001;
        flags              = 5'b00000;
        #3;
        check("nt_strobes", {61'h0, pc_branch_en, pc_jump_en, pc_stall}, 64'h1);
        @(negedge clk);
        redirect_valid = 1'b0;
        #3;
        check("nt_state", {47'h0, instr_valid, taken_count}, {47'h0, 1'b1, 16'h0});
        @(negedge clk);
        redirect_valid = 1'b1;
        flags          = 5'b00001;
        #3;
        check("t_strobes", {61'h0, pc_branch_en, pc_jump_en, pc_stall}, 64'h4);
        @(negedge clk);
        redirect_valid = 1'b0;
        flags          = 5'b00000;
        #3;
        check("t_state", {47'h0, instr_valid, taken_count}, {47'h0, 1'b0, 16'h1});
        check("t_branch_pulses", 64'(br_cnt - b0), 64'h1);
        check("t_pc", 64'(pc_addr), 64'h100);
        @(negedge clk);
        a0 = acc_cnt;
        exp_q.push_back({32'h100, 32'hC0DE0100});
        instr_ready = 1'b1;
        wait_acc(a0 + 1, 20);

        // 5: taken jump during WAIT flushes the stale DEADBEEF response
        @(negedge clk);
        instr_ready  = 1'b0;
        mem_lat      = 3;
        mem_override = 1'b1;
        j0 = jp_cnt;
        wait_req(10, cyc);
        @(negedge clk);
        redirect_valid     = 1'b1;
        redirect_is_branch = 1'b0;
        redirect_cond      = 5'b00000;
        mem_override       = 1'b0;
        #3;
        check("jump_strobe", {62'h0, pc_branch_en, pc_jump_en}, 64'h1);
        @(negedge clk);
        redirect_valid = 1'b0;
        mem_lat        = 1;
        wait_req(10, cyc);
        check("flush_req_addr", 64'(imem_req_addr), 64'h142);
        check("flush_jump_pulses", 64'(jp_cnt - j0), 64'h1);
        check("flush_cnt", 64'(taken_count), 64'h2);
        check("flush_no_stale", 64'(dead_cnt), 64'h0);
        @(negedge clk);
        a0 = acc_cnt;
        exp_q.push_back({32'h142, 32'hC0DE0142});
        instr_ready = 1'b1;
        wait_acc(a0 + 1, 20);

        // 6: saturate the taken counter
        @(negedge clk);
        instr_ready        = 1'b0;
        redirect_valid     = 1'b1;
        redirect_is_branch = 1'b1;
        redirect_cond      = 5'b00000;
        repeat (65532) @(negedge clk);
        #3;
        check("cnt_fffe", 64'(taken_count), 64'hFFFE);
        @(negedge clk);
        #3;
        check("cnt_ffff", 64'(taken_count), 64'hFFFF);
        @(negedge clk);
        #3;
        check("cnt_sat", 64'(taken_count), 64'hFFFF);
        @(negedge clk);
        redirect_valid = 1'b0;

        // 6b: clk_en low during HOLD freezes everything
        wait_ivalid(20);
        @(negedge clk);
        clk_en         = 1'b0;
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            #3;
            check("freeze_ctl", {28'h0, pc_stall, pc_branch_en, pc_jump_en, instr_valid, instr_addr}, {28'h0, 4'b1001, 32'h100});
            check("freeze_cnt", {47'h0, imem_req_valid, taken_count}, {47'h0, 1'b0, 16'hFFFF});
        end
        @(negedge clk);
        clk_en         = 1'b1;
        redirect_valid = 1'b0;
        a0 = acc_cnt;
        exp_q.push_back({32'h100, 32'hC0DE0100});
        wait_acc(a0 + 1, 20);
        @(negedge clk);
        instr_ready = 1'b0;
        #3;

        check("sb_drained", 64'(exp_q.size()), 64'h0);
        check("never_both_strobes", 64'(both_cnt), 64'h0);
        check("never_stale_valid", 64'(dead_cnt), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Controller that drives the program counter and the instruction-memory fetch port. It issues one fetch at a time to instruction memory using a valid/ready request and a valid response, and hands each returned instruction to decode using a valid/ready handshake. It resolves redirect requests from execute into the counter's stall, branch_en and jump_en controls, and it flushes any stale in-flight fetch. It also keeps a saturating count of taken redirects for debug.

Parameters:
INSTR_ADDR_WIDTH, 32, width of instruction byte addresses
INSTR_WIDTH, 32, width of a fetched instruction word
CNT_WIDTH, 16, width of the taken-redirect counter

Ports:
clk  input  1  clock, all state on rising edge
async_rst_n  input  1  asynchronous active-low reset
clk_en  input  1  global enable; low freezes all state and gates strobes
pc_addr  input  INSTR_ADDR_WIDTH  current next_instr_addr from the program counter
pc_stall  output  1  hold the counter
pc_branch_en  output  1  one-cycle strobe: register-relative redirect
pc_jump_en  output  1  one-cycle strobe: PC-relative redirect
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  INSTR_ADDR_WIDTH  fetch address
imem_rsp_valid  input  1  fetch data valid, one cycle
imem_rsp_data  input  INSTR_WIDTH  fetched instruction
instr_valid  output  1  instruction available to decode
instr_ready  input  1  decode accepts
instr_data  output  INSTR_WIDTH  instruction to decode
instr_addr  output  INSTR_ADDR_WIDTH  address of instr_data
redirect_valid  input  1  execute requests redirect, one cycle
redirect_is_branch  input  1  1 = branch (register-relative), 0 = jump (PC-relative)
redirect_cond  input  5  condition mask; 0 = unconditional
flags  input  5  current condition flags
taken_count  output  CNT_WIDTH  saturating count of taken redirects

Behaviour:
- Reset (async, any state): state=IDLE; pc_stall=1; strobes=0; imem_req_valid=0; instr_valid=0; instr_data=0; instr_addr=0; imem_req_addr=0; taken_count=0.
- taken = redirect_valid && (redirect_cond==0 || |(redirect_cond & flags)). A not-taken redirect has no effect on any output.
- Strobes are combinational from taken and state, gated by clk_en:
  - pc_branch_en = taken && redirect_is_branch.
  - pc_jump_en = taken && !redirect_is_branch.
  - Never both high.
- pc_stall = !(taken || advance), where advance = instr_valid && instr_ready && !taken.
- The counter therefore moves exactly once per accepted instruction or per taken redirect.
- FSM states:
  - IDLE: one cycle after reset. Goes to REQ.
  - REQ: imem_req_valid=1 and imem_req_addr=pc_addr, registered on entry. On handshake, go to WAIT.
  - WAIT: waiting for the response. When imem_rsp_valid arrives, latch instr_data and instr_addr, set instr_valid, and go to HOLD.
  - HOLD: instr_valid=1. On instr_ready, clear instr_valid and go to REQ. The new request uses the updated pc_addr, so there is one idle cycle between acceptance and the next request.
  - FLUSH: wait for the outstanding response, discard it (instr_valid stays 0), then go to REQ.
- Taken redirect handling by state:
  - In REQ before the handshake: drop the request and re-enter REQ next cycle with the new pc_addr.
  - In REQ with the handshake in the same cycle: go to FLUSH.
  - In WAIT without a response: go to FLUSH.
  - In WAIT with a response in the same cycle: discard the response and go to REQ.
  - In HOLD: clear instr_valid and go to REQ. If instr_ready is also high that cycle, decode still takes the word, but the counter follows the redirect (advance is suppressed).
- A response arriving outside WAIT/FLUSH is ignored.
- taken_count increments on each taken redirect while clk_en is high, and saturates at all-ones.
- clk_en low: FSM, registers and counter hold; strobes are 0; pc_stall=1. A memory response arriving while clk_en is low is lost; the system must keep clk_en high while a fetch is outstanding.
- Single outstanding fetch only. Addresses pass through unmodified; no alignment check.

Test Plan:
1. Reset mid-WAIT:
   - Stimulus: assert async_rst_n=0 between clock edges.
   - Required: all outputs go to reset values immediately; after release, IDLE then REQ with imem_req_addr=pc_addr.
2. Straight-line fetch:
   - Stimulus: memory ready always, 1-cycle response latency, decode always ready, pc_addr stepping 0x0, 0x2, 0x4.
   - Required: three instructions delivered with instr_addr 0x0, 0x2, 0x4; pc_stall low exactly one cycle per acceptance.
3. Decode backpressure:
   - Stimulus: instr_ready=0 for 4 cycles.
   - Required: instr_valid and instr_data held stable; pc_stall=1; no new imem request.
4. Conditional redirect:
   - Stimulus: redirect_cond=5'b00001, flags=5'b00000, then flags=5'b00001 with redirect_is_branch=1.
   - Required: first redirect has no effect and taken_count=0; second pulses pc_branch_en for 1 cycle and taken_count=1.
5. Flush:
   - Stimulus: taken jump during WAIT; response arrives 2 cycles later with 0xDEADBEEF.
   - Required: pc_jump_en pulses once; 0xDEADBEEF never appears with instr_valid=1; next request uses the redirected pc_addr.
6. Saturation and freeze:
   - Stimulus: preload to 0xFFFF via 65535 taken redirects, then one more; separately, clk_en=0 during HOLD.
   - Required: taken_count stays 0xFFFF; with clk_en=0, state holds, strobes stay 0 and pc_stall=1.
